// File: rtl/wt_pkg.sv
// Shared types and helpers for the dot-product accumulator slice.
package wt_pkg;

  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wt_dot_accum_sat_add.sv
// Unsigned saturating adder: ACC_W-bit accumulator plus one 8-bit product.
module sat_add
  import wt_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  logic [ACC_W:0] wide;

  always_comb begin
    wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
    sat  = wide[ACC_W];
    sum  = sat ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/wt_dot_accum.sv
// Accumulates LEN streamed products into one saturated dot-product sum and
// holds it on a valid/ready output until the sink takes it.
module wt_dot_accum
  import wt_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = clog2(LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             rdy_en_q, rdy_en_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_sat;
  logic             accept;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc     (acc_q),
    .product (product),
    .sum     (add_sum),
    .sat     (add_sat)
  );

  // Input side stays closed until the first edge after reset release.
  assign in_ready  = rdy_en_q && ((state_q == IDLE) || (state_q == ACCUM));
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    rdy_en_d    = 1'b1;

    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      count_d     = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d = add_sum;
            ovf_d = add_sat;
            if (LEN == 1) begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              count_d     = '0;
            end else begin
              state_d = ACCUM;
              count_d = CNT_W'(1);
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_sat;
            if (count_q == LAST) begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              count_d     = '0;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          acc_d       = '0;
          count_d     = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_wt_dot_accum.sv
// Directed bench: three accumulator configurations share one stimulus stream.
module tb_wt_dot_accum;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] product;

  logic       u4_in_ready, u4_out_valid, u4_overflow, u4_busy;
  logic [9:0] u4_acc_out;
  logic       u8_in_ready, u8_out_valid, u8_overflow, u8_busy;
  logic [7:0] u8_acc_out;
  logic       u1_in_ready, u1_out_valid, u1_overflow, u1_busy;
  logic [9:0] u1_acc_out;

  int checks;
  int errors;

  wt_dot_accum #(.LEN(4), .ACC_W(10)) u4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(u4_in_ready), .product(product), .out_valid(u4_out_valid),
    .out_ready(out_ready), .acc_out(u4_acc_out), .overflow(u4_overflow),
    .busy(u4_busy)
  );

  wt_dot_accum #(.LEN(4), .ACC_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(u8_in_ready), .product(product), .out_valid(u8_out_valid),
    .out_ready(out_ready), .acc_out(u8_acc_out), .overflow(u8_overflow),
    .busy(u8_busy)
  );

  wt_dot_accum #(.LEN(1), .ACC_W(10)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(u1_in_ready), .product(product), .out_valid(u1_out_valid),
    .out_ready(out_ready), .acc_out(u1_acc_out), .overflow(u1_overflow),
    .busy(u1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    logic [7:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      product  = v[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; product = 8'd0;
    repeat (2) tick();
    checks++;
    if (u4_out_valid !== 1'b0 || u4_busy !== 1'b0 || u4_acc_out !== 10'd0 || u4_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b b=%b acc=%0d ov=%b want 0 0 0 0",
               u4_out_valid, u4_busy, u4_acc_out, u4_overflow);
    end
    checks++;
    if (u4_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 0", u4_in_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (u4_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready got %b want 1", u4_in_ready);
    end
    $display("reset: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_basic;
    logic [7:0] v [4];
    v[0] = 8'd3; v[1] = 8'd5; v[2] = 8'd7; v[3] = 8'd9;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      product  = v[i];
      checks++;
      if (u4_in_ready !== 1'b1 || u4_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_ready_%0d got rdy=%b v=%b want 1 0", i, u4_in_ready, u4_out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (u4_out_valid !== 1'b1 || u4_acc_out !== 10'd24 || u4_overflow !== 1'b0 || u4_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got v=%b acc=%0d ov=%b rdy=%b want 1 24 0 0",
               u4_out_valid, u4_acc_out, u4_overflow, u4_in_ready);
    end
    tick();
    checks++;
    if (u4_out_valid !== 1'b0 || u4_in_ready !== 1'b1 || u4_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got v=%b rdy=%b busy=%b want 0 1 0",
               u4_out_valid, u4_in_ready, u4_busy);
    end
    $display("basic 3+5+7+9: acc=%0d", 24);
  endtask

  task automatic test_max;
    out_ready = 1'b1;
    feed4(8'd225, 8'd225, 8'd225, 8'd225);
    checks++;
    if (u4_out_valid !== 1'b1 || u4_acc_out !== 10'd900 || u4_overflow !== 1'b0) begin
      errors++;
      $display("FAIL max_result got v=%b acc=%0d ov=%b want 1 900 0",
               u4_out_valid, u4_acc_out, u4_overflow);
    end
    tick();
    $display("max 4x225: expected acc=900");
  endtask

  task automatic test_saturation;
    out_ready = 1'b1;
    feed4(8'd200, 8'd100, 8'd10, 8'd1);
    checks++;
    if (u8_out_valid !== 1'b1 || u8_acc_out !== 8'd255 || u8_overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_result got v=%b acc=%0d ov=%b want 1 255 1",
               u8_out_valid, u8_acc_out, u8_overflow);
    end
    checks++;
    if (u4_acc_out !== 10'd311 || u4_overflow !== 1'b0) begin
      errors++;
      $display("FAIL sat_wide_result got acc=%0d ov=%b want 311 0", u4_acc_out, u4_overflow);
    end
    tick();
    feed4(8'd1, 8'd1, 8'd1, 8'd1);
    checks++;
    if (u8_out_valid !== 1'b1 || u8_acc_out !== 8'd4 || u8_overflow !== 1'b0) begin
      errors++;
      $display("FAIL sat_next_result got v=%b acc=%0d ov=%b want 1 4 0",
               u8_out_valid, u8_acc_out, u8_overflow);
    end
    tick();
    $display("saturation: expected 255/ov then 4/no-ov");
  endtask

  task automatic test_back_to_back;
    logic [7:0] v [4];
    v[0] = 8'd10; v[1] = 8'd20; v[2] = 8'd30; v[3] = 8'd40;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; product = v[i];
      tick();
      if (i < 3) begin
        in_valid = 1'b0; product = 8'd99;
        tick();
      end
    end
    in_valid = 1'b1; product = 8'd50;
    for (int s = 0; s < 5; s++) begin
      checks++;
      if (u4_out_valid !== 1'b1 || u4_acc_out !== 10'd100 || u4_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d got v=%b acc=%0d rdy=%b want 1 100 0",
                 s, u4_out_valid, u4_acc_out, u4_in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (u4_out_valid !== 1'b0 || u4_acc_out !== 10'd0 || u4_in_ready !== 1'b1 || u4_busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got v=%b acc=%0d rdy=%b busy=%b want 0 0 1 0",
               u4_out_valid, u4_acc_out, u4_in_ready, u4_busy);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (u4_acc_out !== 10'd50 || u4_busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_next_accept got acc=%0d busy=%b want 50 1", u4_acc_out, u4_busy);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (u4_busy !== 1'b0 || u4_acc_out !== 10'd0) begin
      errors++;
      $display("FAIL stall_cleanup got busy=%b acc=%0d want 0 0", u4_busy, u4_acc_out);
    end
    $display("backpressure: expected acc=100 held 5 cycles");
  endtask

  task automatic test_clear;
    out_ready = 1'b1;
    in_valid = 1'b1; product = 8'd100; tick();
    product = 8'd50; tick();
    checks++;
    if (u4_acc_out !== 10'd150 || u4_busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_partial got acc=%0d busy=%b want 150 1", u4_acc_out, u4_busy);
    end
    clear = 1'b1; product = 8'd7;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if (u4_busy !== 1'b0 || u4_acc_out !== 10'd0 || u4_out_valid !== 1'b0 || u4_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_state got busy=%b acc=%0d v=%b rdy=%b want 0 0 0 1",
               u4_busy, u4_acc_out, u4_out_valid, u4_in_ready);
    end
    feed4(8'd1, 8'd2, 8'd3, 8'd4);
    checks++;
    if (u4_out_valid !== 1'b1 || u4_acc_out !== 10'd10 || u4_overflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_next_result got v=%b acc=%0d ov=%b want 1 10 0",
               u4_out_valid, u4_acc_out, u4_overflow);
    end
    tick();
    $display("clear: expected acc=10 after abort");
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    in_valid = 1'b1; product = 8'd60; tick();
    product = 8'd70; tick();
    in_valid = 1'b0;
    checks++;
    if (u4_acc_out !== 10'd130 || u4_busy !== 1'b1) begin
      errors++;
      $display("FAIL async_partial got acc=%0d busy=%b want 130 1", u4_acc_out, u4_busy);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (u4_out_valid !== 1'b0 || u4_busy !== 1'b0 || u4_acc_out !== 10'd0) begin
      errors++;
      $display("FAIL async_clear got v=%b busy=%b acc=%0d want 0 0 0",
               u4_out_valid, u4_busy, u4_acc_out);
    end
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (u1_in_ready !== 1'b1 || u1_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL len1_idle got rdy=%b v=%b want 1 0", u1_in_ready, u1_out_valid);
    end
    in_valid = 1'b1; product = 8'd225;
    tick();
    in_valid = 1'b0;
    checks++;
    if (u1_out_valid !== 1'b1 || u1_acc_out !== 10'd225 || u1_overflow !== 1'b0 || u1_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL len1_result got v=%b acc=%0d ov=%b rdy=%b want 1 225 0 0",
               u1_out_valid, u1_acc_out, u1_overflow, u1_in_ready);
    end
    tick();
    checks++;
    if (u1_out_valid !== 1'b0 || u1_busy !== 1'b0) begin
      errors++;
      $display("FAIL len1_release got v=%b busy=%b want 0 0", u1_out_valid, u1_busy);
    end
    $display("async reset then LEN=1 225: expected acc=225");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_max();
    test_saturation();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
